// File: rtl/ps_tx_pkg.sv
// Shared types and constants for the parallel-to-serial transmit path.
package ps_tx_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM_DEF  = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_DEF = 8'h7C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/ps_tx_ctrl_if.sv
// Byte-side handshake and serial-side outputs of the transmit sequencer.
interface ps_tx_ctrl_if #(parameter int CNT_W = 16);

  logic             tx_en;
  logic             valid;
  logic [7:0]       data_in;
  logic             ready;
  logic             data_out;
  logic             synced;
  logic [CNT_W-1:0] byte_cnt;

  modport master (output tx_en, valid, data_in,
                  input  ready, data_out, synced, byte_cnt);

  modport slave  (input  tx_en, valid, data_in,
                  output ready, data_out, synced, byte_cnt);

endinterface

// File: rtl/ps_shift8.sv
// 8-bit MSB-first load/shift register with bit counter; boundary marks the last bit of a byte.
// Held at INIT_VAL while not running; loads load_val on the boundary edge, no added latency.
module ps_shift8
  import ps_tx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] INIT_VAL = COM_DEF
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic              run,
  input  logic [BYTE_W-1:0] load_val,
  output logic              msb,
  output logic              boundary
);

  logic [BYTE_W-1:0] sr;
  logic [2:0]        bit_cnt;

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      sr      <= INIT_VAL;
      bit_cnt <= 3'd0;
    end else if (!run) begin
      sr      <= INIT_VAL;
      bit_cnt <= 3'd0;
    end else if (boundary) begin
      sr      <= load_val;
      bit_cnt <= 3'd0;
    end else begin
      sr      <= {sr[BYTE_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign msb      = sr[BYTE_W-1];
  assign boundary = (bit_cnt == 3'd7);

endmodule

// File: rtl/ps_tx_ctrl.sv
// Transmit sequencer: COM preamble after enable, then one byte per 8 bit clocks (IDLE fill if no valid).
// ready is a one-cycle load strobe on the byte boundary; tx_en only takes effect at byte boundaries.
module ps_tx_ctrl
  import ps_tx_pkg::*;
#(
  parameter int          SYNC_BYTES = 4,
  parameter logic [7:0]  COM_CHAR   = COM_DEF,
  parameter logic [7:0]  IDLE_CHAR  = IDLE_DEF,
  parameter int          CNT_W      = 16
) (
  input  logic        dclk,
  input  logic        reset,
  ps_tx_ctrl_if.slave bus
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  state_t           state, state_nxt;
  logic [3:0]       sync_cnt, sync_cnt_nxt;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       load_val;
  logic             boundary;
  logic             msb;
  logic             ready;

  ps_shift8 #(.INIT_VAL(COM_CHAR)) u_shift (
    .dclk     (dclk),
    .reset    (reset),
    .run      (state != ST_IDLE),
    .load_val (load_val),
    .msb      (msb),
    .boundary (boundary)
  );

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sync_cnt <= 4'd0;
      byte_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
      if (ready && bus.valid)
        byte_cnt <= byte_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    load_val     = COM_CHAR;
    ready        = boundary & bus.tx_en &
                   ((state == ST_ACTIVE) | ((state == ST_SYNC) & (sync_cnt == SYNC_LAST)));

    case (state)
      ST_IDLE: begin
        if (bus.tx_en)
          state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (boundary) begin
          if (!bus.tx_en) begin
            state_nxt    = ST_IDLE;
            sync_cnt_nxt = 4'd0;
          end else if (sync_cnt < SYNC_LAST) begin
            sync_cnt_nxt = sync_cnt + 4'd1;
          end else begin
            state_nxt    = ST_ACTIVE;
            sync_cnt_nxt = 4'd0;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary && !bus.tx_en)
          state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt    = ST_IDLE;
        sync_cnt_nxt = 4'd0;
      end
    endcase

    // Data bytes are passed through verbatim, even if they alias COM or IDLE.
    if (ready)
      load_val = bus.valid ? bus.data_in : IDLE_CHAR;
  end

  assign bus.ready    = ready;
  assign bus.data_out = (state != ST_IDLE) & msb;
  assign bus.synced   = (state == ST_ACTIVE);
  assign bus.byte_cnt = byte_cnt;

endmodule

// File: tb/tb_ps_tx_ctrl.sv
// Directed bench for ps_tx_ctrl: preamble, data, disable, mid-byte reset and counter wrap.
module tb_ps_tx_ctrl;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  logic       dclk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       valid;
  logic [7:0] data_in;

  int tests_run    = 0;
  int tests_failed = 0;

  ps_tx_ctrl_if #(.CNT_W(16)) bus ();
  ps_tx_ctrl_if #(.CNT_W(4))  bus_s ();

  assign bus.tx_en     = tx_en;
  assign bus.valid     = valid;
  assign bus.data_in   = data_in;
  assign bus_s.tx_en   = tx_en;
  assign bus_s.valid   = valid;
  assign bus_s.data_in = data_in;

  ps_tx_ctrl #(.SYNC_BYTES(4), .CNT_W(16)) dut (
    .dclk  (dclk),
    .reset (reset),
    .bus   (bus)
  );

  ps_tx_ctrl #(.SYNC_BYTES(4), .CNT_W(4)) dut_s (
    .dclk  (dclk),
    .reset (reset),
    .bus   (bus_s)
  );

  always #5 dclk = ~dclk;

  task automatic test_reset;
    reset = 1'b1; tx_en = 1'b0; valid = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge dclk);
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge dclk);
      tests_run++;
      if ({bus.data_out, bus.ready, bus.synced} !== 3'b000 || bus.byte_cnt !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_idle c=%0d got dout/rdy/sync=%b%b%b cnt=%0d exp 000 cnt=0",
                 c, bus.data_out, bus.ready, bus.synced, bus.byte_cnt);
      end
    end
  endtask

  // Preamble then IDLE fill; leaves the bench at cycle 40 with A5 presented.
  task automatic test_sync;
    logic [7:0] b;
    logic       e;
    tx_en = 1'b1; valid = 1'b0;
    @(posedge dclk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge dclk);
      b = (c <= 32) ? COM : IDL;
      e = b[7 - ((c - 1) % 8)];
      tests_run++;
      if (bus.data_out !== e) begin
        tests_failed++;
        $display("FAIL sync_dout c=%0d got=%b exp=%b", c, bus.data_out, e);
      end
      tests_run++;
      if (bus.ready !== (c == 32 || c == 40)) begin
        tests_failed++;
        $display("FAIL sync_ready c=%0d got=%b exp=%b", c, bus.ready, (c == 32 || c == 40));
      end
      tests_run++;
      if (bus.synced !== (c >= 33)) begin
        tests_failed++;
        $display("FAIL sync_synced c=%0d got=%b exp=%b", c, bus.synced, (c >= 33));
      end
    end
    tests_run++;
    if (bus.byte_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL sync_cnt got=%0d exp=0", bus.byte_cnt);
    end
    valid = 1'b1; data_in = 8'hA5;
  endtask

  task automatic test_data;
    logic [7:0] dat [3];
    logic [7:0] b;
    logic       e;
    dat = '{8'hA5, 8'h3C, 8'hFF};
    for (int c = 41; c <= 64; c++) begin
      @(negedge dclk);
      b = dat[(c - 41) / 8];
      e = b[7 - ((c - 41) % 8)];
      tests_run++;
      if (bus.data_out !== e) begin
        tests_failed++;
        $display("FAIL data_dout c=%0d got=%b exp=%b", c, bus.data_out, e);
      end
      tests_run++;
      if (bus.ready !== (c % 8 == 0)) begin
        tests_failed++;
        $display("FAIL data_ready c=%0d got=%b exp=%b", c, bus.ready, (c % 8 == 0));
      end
      if (c == 48) data_in = 8'h3C;
      if (c == 56) data_in = 8'hFF;
      if (c == 64) begin
        tests_run++;
        if (bus.byte_cnt !== 16'd3) begin
          tests_failed++;
          $display("FAIL data_cnt got=%0d exp=3", bus.byte_cnt);
        end
        valid = 1'b0;
      end
    end
  endtask

  // Drop tx_en mid-byte, then re-enable; ends at cycle 33 of the new preamble.
  task automatic test_drop;
    logic [7:0] b;
    logic       e;
    for (int c = 65; c <= 73; c++) begin
      @(negedge dclk);
      b = IDL;
      e = (c <= 72) ? b[7 - ((c - 65) % 8)] : 1'b0;
      tests_run++;
      if (bus.data_out !== e || bus.ready !== 1'b0 || bus.synced !== (c <= 72)) begin
        tests_failed++;
        $display("FAIL drop c=%0d got dout/rdy/sync=%b%b%b exp %b0%b",
                 c, bus.data_out, bus.ready, bus.synced, e, (c <= 72));
      end
      if (c == 67) tx_en = 1'b0;
      if (c == 68) begin valid = 1'b1; data_in = 8'h55; end
    end
    tests_run++;
    if (bus.byte_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL drop_cnt got=%0d exp=3", bus.byte_cnt);
    end
    valid = 1'b0;
    repeat (3) begin
      @(negedge dclk);
      tests_run++;
      if (bus.data_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL drop_idle got=%b exp=0", bus.data_out);
      end
    end
    tx_en = 1'b1;
    @(posedge dclk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge dclk);
      b = COM;
      e = (c <= 32) ? b[7 - ((c - 1) % 8)] : 1'b1;
      tests_run++;
      if (bus.data_out !== e || bus.ready !== (c == 32) || bus.synced !== (c == 33)) begin
        tests_failed++;
        $display("FAIL resync c=%0d got dout/rdy/sync=%b%b%b exp %b%b%b",
                 c, bus.data_out, bus.ready, bus.synced, e, (c == 32), (c == 33));
      end
      if (c == 32) begin valid = 1'b1; data_in = 8'hA5; end
      if (c == 33) valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'hA5;
    for (int c = 34; c <= 36; c++) begin
      @(negedge dclk);
      tests_run++;
      if (bus.data_out !== b[7 - (c - 33)] || bus.byte_cnt !== 16'd4) begin
        tests_failed++;
        $display("FAIL mid_pre c=%0d got dout=%b cnt=%0d exp dout=%b cnt=4",
                 c, bus.data_out, bus.byte_cnt, b[7 - (c - 33)]);
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.data_out, bus.ready, bus.synced} !== 3'b000 || bus.byte_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset got dout/rdy/sync=%b%b%b cnt=%0d exp 000 cnt=0",
               bus.data_out, bus.ready, bus.synced, bus.byte_cnt);
    end
    repeat (4) begin
      @(negedge dclk);
      tests_run++;
      if (bus.data_out !== 1'b0 || bus.ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_hold got dout=%b rdy=%b exp 0 0", bus.data_out, bus.ready);
      end
    end
    tx_en = 1'b0;
    reset = 1'b0;
    repeat (4) begin
      @(negedge dclk);
      tests_run++;
      if (bus.data_out !== 1'b0 || bus.synced !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_after got dout=%b sync=%b exp 0 0", bus.data_out, bus.synced);
      end
    end
  endtask

  task automatic test_wrap;
    tx_en = 1'b1; valid = 1'b1; data_in = 8'h11;
    @(posedge dclk);
    for (int c = 1; c <= 161; c++) begin
      @(negedge dclk);
      tests_run++;
      if (bus_s.ready !== (c >= 32 && c % 8 == 0)) begin
        tests_failed++;
        $display("FAIL wrap_ready c=%0d got=%b exp=%b", c, bus_s.ready, (c >= 32 && c % 8 == 0));
      end
      if (c == 145) begin
        tests_run++;
        if (bus_s.byte_cnt !== 4'hF) begin
          tests_failed++;
          $display("FAIL wrap_15 got=%0d exp=15", bus_s.byte_cnt);
        end
      end
      if (c == 153) begin
        tests_run++;
        if (bus_s.byte_cnt !== 4'h0) begin
          tests_failed++;
          $display("FAIL wrap_16 got=%0d exp=0", bus_s.byte_cnt);
        end
      end
      if (c == 161) begin
        tests_run++;
        if (bus_s.byte_cnt !== 4'h1) begin
          tests_failed++;
          $display("FAIL wrap_17 got=%0d exp=1", bus_s.byte_cnt);
        end
        tests_run++;
        if (bus.byte_cnt !== 16'd17) begin
          tests_failed++;
          $display("FAIL wide_17 got=%0d exp=17", bus.byte_cnt);
        end
      end
    end
    tx_en = 1'b0; valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync();
    test_data();
    test_drop();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps_tx_ctrl.md
Name: ps_tx_ctrl

Overview:
- Transmit-side sequencer for the parallel-to-serial path. Runs on the bit clock `dclk`.
- Paces the byte producer with a one-cycle `ready` strobe and loads each byte into an 8-bit shifter. Bytes go out MSB first on `data_out`.
- Emits a COM synchronisation preamble after enable, and IDLE fill whenever the producer has no valid byte.
- Sits between the probador/core-side byte source (`valid`, `data_in`) and the serial line consumed by the receive-side converter.

Parameters:
- SYNC_BYTES, 4: number of COM bytes sent before data is accepted; legal range 1..15.
- COM_CHAR, 8'hBC: synchronisation character.
- IDLE_CHAR, 8'h7C: fill character sent when `valid`=0 in ACTIVE.
- CNT_W, 16: width of the accepted-byte counter.

Ports:
- dclk  in  1  bit clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_en  in  1  transmitter enable.
- valid  in  1  producer has a byte; sampled only while `ready`=1.
- data_in  in  8  byte to transmit; sampled only while `ready`=1.
- ready  out  1  load strobe: `valid`/`data_in` are captured on this edge.
- data_out  out  1  serial bit stream, MSB first.
- synced  out  1  high while state=ACTIVE.
- byte_cnt  out  CNT_W  count of accepted data bytes (`ready`&`valid`); wraps to 0.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, bit_cnt=0, sr=COM_CHAR, sync_cnt=0, byte_cnt=0.
  - Outputs: data_out=0, ready=0, synced=0, byte_cnt=0.
- Output definitions:
  - data_out = sr[7] when state≠IDLE, else 0. This is a direct register output; there is no added latency.
  - boundary = (bit_cnt==7).
  - ready = boundary & tx_en & (state==ACTIVE | (state==SYNC & sync_cnt==SYNC_BYTES-1)).
- States: IDLE, SYNC, ACTIVE. Encoding lives in the package.
- IDLE:
  - sr held at COM_CHAR; bit_cnt held at 0.
  - tx_en=1 → SYNC on the next edge. sr stays COM_CHAR, so the first COM bit appears the cycle after the transition.
- SYNC/ACTIVE, every edge:
  - If not boundary: sr <= sr<<1, bit_cnt++.
  - At boundary: bit_cnt <= 0, and sr <= next byte per the rules below.
- SYNC at boundary:
  - tx_en=0 → IDLE, sr <= COM_CHAR, sync_cnt <= 0.
  - Else if sync_cnt < SYNC_BYTES-1: sync_cnt++, sr <= COM_CHAR.
  - Else: → ACTIVE, sync_cnt <= 0, sr <= (valid ? data_in : IDLE_CHAR). `ready` is high on this edge.
- ACTIVE at boundary:
  - tx_en=1: sr <= (valid ? data_in : IDLE_CHAR); byte_cnt += valid (mod 2^CNT_W).
  - tx_en=0: ready=0, → IDLE, sr <= COM_CHAR. The producer's byte is not consumed.
- tx_en is evaluated only at byte boundaries (and in IDLE). The byte in flight always completes; no partial bytes are ever emitted.
- A byte presented with `valid`=1 while `ready`=0 is ignored. The producer must hold it until `ready`.
- Latency: tx_en sampled high in IDLE at edge E0 →
  - COM bits occupy cycles 1..8·SYNC_BYTES;
  - first `ready` at cycle 8·SYNC_BYTES;
  - first data bit (MSB) at cycle 8·SYNC_BYTES+1;
  - each byte's MSB appears 1 cycle after its `ready` edge.
- Reset asserted mid-byte: immediate return to reset state; the partial byte is truncated and byte_cnt is cleared.
- byte_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- data_in is written into the data path even if its value equals COM_CHAR or IDLE_CHAR. Escaping is the producer's responsibility.

Decomposition:
- Package ps_tx_pkg:
  - state encodings ST_IDLE/ST_SYNC/ST_ACTIVE;
  - default COM_CHAR/IDLE_CHAR constants;
  - BYTE_W=8.
- One sub-module, ps_shift8: 8-bit load/shift register plus 3-bit bit counter, with a boundary output. The FSM, sync counter, handshake and byte_cnt stay in ps_tx_ctrl.

Test Plan:
- Reset, tx_en=0 for 20 cycles → data_out=0, ready=0, synced=0, byte_cnt=0 throughout.
- tx_en=1 at E0, SYNC_BYTES=4, valid=0 → data_out carries 0xBC four times MSB first (1,0,1,1,1,1,0,0) in cycles 1–32. ready=1 only at cycle 32; synced rises after cycle 32. Cycles 33–40 carry 0x7C; byte_cnt stays 0.
- Once synced, present valid=1 with 0xA5, 0x3C, 0xFF on successive ready strobes → serial stream A5,3C,FF. ready is spaced exactly 8 cycles apart; byte_cnt=3.
- Drop tx_en mid-byte in ACTIVE → current byte completes all 8 bits. At that boundary ready=0 and state=IDLE; data_out=0 next cycle. Re-enable → full 4-byte COM preamble repeats.
- Assert reset at bit 3 of a data byte → data_out=0 and ready=0 immediately, byte_cnt=0, no further bits emitted.
- CNT_W=4, 17 valid bytes → byte_cnt reads 0xF after 15 bytes, 0 after 16, 1 after 17.
